// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and execute-side resolve signals of the branch predictor.
// master = pipeline driving PCs/resolves, slave = the predictor.
interface branch_predictor_if;
  logic [31:0] fetchPc;
  logic [31:0] predictedNextPc;
  logic        isBranchTakenPredicted;
  logic        isNextPcPredicted;
  logic        exIsBranch;
  logic        exBranchTaken;
  logic [31:0] exPc;
  logic [31:0] exIrregPc;
  logic [31:0] exPredictedNextPc;
  logic        isBranchPredictMiss;
  logic [31:0] recoveryPc;
  logic [31:0] branchCount;
  logic [31:0] missCount;

  modport master (
    output fetchPc, exIsBranch, exBranchTaken, exPc, exIrregPc, exPredictedNextPc,
    input  predictedNextPc, isBranchTakenPredicted, isNextPcPredicted,
           isBranchPredictMiss, recoveryPc, branchCount, missCount
  );

  modport slave (
    input  fetchPc, exIsBranch, exBranchTaken, exPc, exIrregPc, exPredictedNextPc,
    output predictedNextPc, isBranchTakenPredicted, isNextPcPredicted,
           isBranchPredictMiss, recoveryPc, branchCount, missCount
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational; table and statistics update on the falling clock edge.
module branch_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic               clk,
  input  logic               rst,
  branch_predictor_if.slave  bp
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TAG_W-1:0] tag_t;

  function automatic logic [1:0] satInc(input logic [1:0] c);
    return (c == 2'd3) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] satDec(input logic [1:0] c);
    return (c == 2'd0) ? c : c - 2'd1;
  endfunction

  logic        validMem  [ENTRIES];
  logic [1:0]  ctrMem    [ENTRIES];
  tag_t        tagMem    [ENTRIES];
  logic [31:0] targetMem [ENTRIES];

  logic [31:0] branchCnt;
  logic [31:0] missCnt;

  idx_t        fetchIdx;
  idx_t        exIdx;
  tag_t        fetchTag;
  tag_t        exTag;
  logic        fetchHit;
  logic        exHit;
  logic        predictTaken;
  logic [31:0] fetchPlus4;
  logic [31:0] exPlus4;
  logic [31:0] actualNextPc;
  logic        missRaw;
  logic        hitUpdate;
  logic        allocate;
  logic        writeTarget;

  // Fetch-side lookup
  assign fetchIdx     = bp.fetchPc[IDX_W+1:2];
  assign fetchTag     = bp.fetchPc[31:IDX_W+2];
  assign fetchHit     = validMem[fetchIdx] && (tagMem[fetchIdx] == fetchTag);
  assign predictTaken = fetchHit && ctrMem[fetchIdx][1];
  assign fetchPlus4   = bp.fetchPc + 32'd4;

  // Outputs are forced to zero while reset is held, even though lookup is combinational.
  assign bp.isNextPcPredicted      = rst && fetchHit;
  assign bp.isBranchTakenPredicted = rst && predictTaken;
  assign bp.predictedNextPc        = !rst        ? 32'd0 :
                                     predictTaken ? targetMem[fetchIdx] : fetchPlus4;

  // Execute-side resolve
  assign exIdx        = bp.exPc[IDX_W+1:2];
  assign exTag        = bp.exPc[31:IDX_W+2];
  assign exHit        = validMem[exIdx] && (tagMem[exIdx] == exTag);
  assign exPlus4      = bp.exPc + 32'd4;
  assign actualNextPc = bp.exBranchTaken ? bp.exIrregPc : exPlus4;
  assign missRaw      = bp.exIsBranch && (actualNextPc != bp.exPredictedNextPc);

  assign bp.isBranchPredictMiss = rst && missRaw;
  assign bp.recoveryPc          = (rst && bp.exIsBranch) ? actualNextPc : 32'd0;

  assign hitUpdate   = bp.exIsBranch && exHit;
  assign allocate    = bp.exIsBranch && !exHit && bp.exBranchTaken;
  assign writeTarget = bp.exIsBranch && bp.exBranchTaken;

  // Table control state: valid bits and direction counters
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        validMem[i] <= 1'b0;
        ctrMem[i]   <= 2'd0;
      end
    end else if (allocate) begin
      validMem[exIdx] <= 1'b1;
      ctrMem[exIdx]   <= 2'd2;
    end else if (hitUpdate) begin
      ctrMem[exIdx] <= bp.exBranchTaken ? satInc(ctrMem[exIdx]) : satDec(ctrMem[exIdx]);
    end
  end

  // Tag/target payload carries no reset; an invalid entry never exposes it.
  always_ff @(negedge clk) begin
    if (writeTarget) begin
      targetMem[exIdx] <= bp.exIrregPc;
    end
    if (allocate) begin
      tagMem[exIdx] <= exTag;
    end
  end

  // Statistics counters, free-running with natural 32-bit wrap
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      branchCnt <= 32'd0;
      missCnt   <= 32'd0;
    end else begin
      if (bp.exIsBranch) begin
        branchCnt <= branchCnt + 32'd1;
      end
      if (missRaw) begin
        missCnt <= missCnt + 32'd1;
      end
    end
  end

  assign bp.branchCount = branchCnt;
  assign bp.missCount   = missCnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a reference table model pushes expected
// outputs to a scoreboard queue, popped and compared when the DUT is sampled.
module tb_branch_predictor;

  localparam int ENT = 16;

  logic clk;
  logic rst;

  branch_predictor_if bp ();

  branch_predictor #(.ENTRIES(ENT)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

  // Reference model state
  logic        mValid  [ENT];
  logic [31:0] mUpper  [ENT];
  logic [31:0] mTarget [ENT];
  int          mCtr    [ENT];
  logic [31:0] mBr;
  logic [31:0] mMiss;

  task automatic modelReset();
    for (int i = 0; i < ENT; i++) begin
      mValid[i]  = 1'b0;
      mUpper[i]  = 32'd0;
      mTarget[i] = 32'd0;
      mCtr[i]    = 0;
    end
    mBr   = 32'd0;
    mMiss = 32'd0;
  endtask

  task automatic expectVal(input string n, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic observe(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      e.name = "scoreboard_empty";
      e.val  = 32'hxxxxxxxx;
    end else begin
      e = sb.pop_front();
    end
    total++;
    assert (obs === e.val) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", e.name, obs, e.val);
    end
  endtask

  task automatic expectAllZero();
    expectVal("rst_predictedNextPc", 32'd0);
    expectVal("rst_isBranchTakenPredicted", 32'd0);
    expectVal("rst_isNextPcPredicted", 32'd0);
    expectVal("rst_isBranchPredictMiss", 32'd0);
    expectVal("rst_recoveryPc", 32'd0);
    expectVal("rst_branchCount", 32'd0);
    expectVal("rst_missCount", 32'd0);
    observe(bp.predictedNextPc);
    observe({31'd0, bp.isBranchTakenPredicted});
    observe({31'd0, bp.isNextPcPredicted});
    observe({31'd0, bp.isBranchPredictMiss});
    observe(bp.recoveryPc);
    observe(bp.branchCount);
    observe(bp.missCount);
  endtask

  task automatic modelUpdate(input logic br, input logic tk, input logic [31:0] pc,
                             input logic [31:0] tgt, input logic miss);
    int  ei;
    logic hit;
    ei  = int'(pc[5:2]);
    hit = mValid[ei] && (mUpper[ei] == (pc >> 6));
    if (br) begin
      mBr = mBr + 32'd1;
      if (miss) mMiss = mMiss + 32'd1;
      if (hit) begin
        if (tk) begin
          mCtr[ei]    = (mCtr[ei] < 3) ? mCtr[ei] + 1 : 3;
          mTarget[ei] = tgt;
        end else begin
          mCtr[ei] = (mCtr[ei] > 0) ? mCtr[ei] - 1 : 0;
        end
      end else if (tk) begin
        mValid[ei]  = 1'b1;
        mUpper[ei]  = pc >> 6;
        mTarget[ei] = tgt;
        mCtr[ei]    = 2;
      end
    end
  endtask

  // One cycle: drive after rising edge, check lookup/resolve before the falling
  // (update) edge, then check statistics after it.
  task automatic step(input logic [31:0] f, input logic br, input logic tk,
                      input logic [31:0] pc, input logic [31:0] tgt, input logic [31:0] pnext);
    int          fi;
    logic        hit;
    logic        tkPred;
    logic [31:0] actual;
    logic        miss;
    @(posedge clk);
    bp.fetchPc           = f;
    bp.exIsBranch        = br;
    bp.exBranchTaken     = tk;
    bp.exPc              = pc;
    bp.exIrregPc         = tgt;
    bp.exPredictedNextPc = pnext;
    fi     = int'(f[5:2]);
    hit    = mValid[fi] && (mUpper[fi] == (f >> 6));
    tkPred = hit && (mCtr[fi] >= 2);
    actual = tk ? tgt : pc + 32'd4;
    miss   = br && (actual != pnext);
    expectVal("predictedNextPc", tkPred ? mTarget[fi] : f + 32'd4);
    expectVal("isBranchTakenPredicted", {31'd0, tkPred});
    expectVal("isNextPcPredicted", {31'd0, hit});
    expectVal("isBranchPredictMiss", {31'd0, miss});
    expectVal("recoveryPc", br ? actual : 32'd0);
    #1;
    observe(bp.predictedNextPc);
    observe({31'd0, bp.isBranchTakenPredicted});
    observe({31'd0, bp.isNextPcPredicted});
    observe({31'd0, bp.isBranchPredictMiss});
    observe(bp.recoveryPc);
    modelUpdate(br, tk, pc, tgt, miss);
    expectVal("branchCount", mBr);
    expectVal("missCount", mMiss);
    @(negedge clk);
    #1;
    observe(bp.branchCount);
    observe(bp.missCount);
  endtask

  // Reset pulsed between edges while a taken branch is on the resolve port;
  // the first falling edge after release must perform that update.
  task automatic pulseReset();
    @(posedge clk);
    bp.fetchPc           = 32'h100;
    bp.exIsBranch        = 1'b1;
    bp.exBranchTaken     = 1'b1;
    bp.exPc              = 32'h300;
    bp.exIrregPc         = 32'h380;
    bp.exPredictedNextPc = 32'h304;
    #1;
    rst = 1'b0;
    #1;
    expectAllZero();
    modelReset();
    #1;
    rst = 1'b1;
    modelUpdate(1'b1, 1'b1, 32'h300, 32'h380, 1'b1);
    expectVal("postrst_branchCount", 32'd1);
    expectVal("postrst_missCount", 32'd1);
    @(negedge clk);
    #1;
    observe(bp.branchCount);
    observe(bp.missCount);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    modelReset();
    rst                  = 1'b0;
    bp.fetchPc           = 32'h100;
    bp.exIsBranch        = 1'b1;
    bp.exBranchTaken     = 1'b1;
    bp.exPc              = 32'h100;
    bp.exIrregPc         = 32'h200;
    bp.exPredictedNextPc = 32'h104;
    #2;
    expectAllZero();
    @(negedge clk);
    #1;
    expectAllZero();

    @(posedge clk);
    bp.exIsBranch = 1'b0;
    #1;
    rst = 1'b1;
    @(negedge clk);
    #1;
    expectVal("idle_branchCount", 32'd0);
    observe(bp.branchCount);

    // cold miss
    step(32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    // allocate; same-cycle lookup still sees the empty entry
    step(32'h100, 1'b1, 1'b1, 32'h100, 32'h200, 32'h104);
    expectVal("alloc_missCount_is_1", 32'd1);
    observe(bp.missCount);
    step(32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    expectVal("alloc_predicts_0x200", 32'h200);
    observe(bp.predictedNextPc);
    // hysteresis: not-taken drops to 1, lookup in same cycle still taken
    step(32'h100, 1'b1, 1'b0, 32'h100, 32'h200, 32'h200);
    step(32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(32'h100, 1'b1, 1'b1, 32'h100, 32'h200, 32'h200);
    end
    step(32'h100, 1'b1, 1'b0, 32'h100, 32'h200, 32'h200);
    step(32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    // aliasing on index 0
    step(32'h140, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    step(32'h140, 1'b1, 1'b1, 32'h140, 32'h500, 32'h144);
    step(32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    step(32'h140, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    // not-taken miss leaves the table alone
    step(32'h208, 1'b1, 1'b0, 32'h208, 32'h300, 32'h20C);
    step(32'h208, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    // wrong prediction on a not-taken branch
    step(32'h208, 1'b1, 1'b0, 32'h208, 32'h300, 32'h300);
    // PC+4 wrap at the top of the address space
    step(32'hFFFF_FFFC, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0);
    // asynchronous reset mid-operation
    pulseReset();
    step(32'h300, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    step(32'h140, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

    @(posedge clk);
    total++;
    assert (sb.size() == 0) passed++;
    else begin
      failed++;
      $error("FAIL scoreboard_drain: observed %0d expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL take parameter ENTRIES, default 16, as the number of direct-mapped table entries (power of two, 4..64).
REQ-002 SHALL have `clk  in  1`: the single clock; all state updates on the falling edge, matching the pipeline registers.
REQ-003 SHALL have `rst  in  1`: asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have `fetchPc  in  32`: PC currently being fetched.
REQ-005 SHALL have `predictedNextPc  out  32`: predicted PC following fetchPc.
REQ-006 SHALL have `isBranchTakenPredicted  out  1`: the table hit and predicts taken.
REQ-007 SHALL have `isNextPcPredicted  out  1`: the table hit for fetchPc.
REQ-008 SHALL have `exIsBranch  in  1`: the execute stage resolved a branch or jump this cycle.
REQ-009 SHALL have `exBranchTaken  in  1`: the resolved direction.
REQ-010 SHALL have `exPc  in  32`: PC of the resolved instruction.
REQ-011 SHALL have `exIrregPc  in  32`: resolved target address.
REQ-012 SHALL have `exPredictedNextPc  in  32`: the prediction that travelled down the pipe with that instruction.
REQ-013 SHALL have `isBranchPredictMiss  out  1`: the resolved next PC differs from the prediction.
REQ-014 SHALL have `recoveryPc  out  32`: the correct next PC for fetch redirect.
REQ-015 SHALL have `branchCount  out  32`: count of resolved branches.
REQ-016 SHALL have `missCount  out  32`: count of mispredicts.

Function
REQ-017 Index SHALL be pc[log2(ENTRIES)+1:2]; tag SHALL be pc[31:log2(ENTRIES)+2]; each entry SHALL hold valid, tag, 32-bit target and a 2-bit saturating counter.
REQ-018 Lookup SHALL be combinational: hit = valid && tag match on fetchPc.
- isNextPcPredicted = hit.
- isBranchTakenPredicted = hit && counter[1].
- predictedNextPc = isBranchTakenPredicted ? target : fetchPc+4 (mod 2^32).
REQ-019 actualNextPc SHALL be exBranchTaken ? exIrregPc : exPc+4 (mod 2^32).
REQ-020 isBranchPredictMiss SHALL equal exIsBranch && (actualNextPc != exPredictedNextPc), combinationally; recoveryPc SHALL equal actualNextPc when exIsBranch is 1, otherwise 0.
REQ-021 On a clock edge with exIsBranch=1 and a hit on exPc:
- counter increments (saturating at 3) if taken, decrements (saturating at 0) if not taken;
- target is overwritten with exIrregPc if taken.
REQ-022 On a clock edge with exIsBranch=1, a miss on exPc, and exBranchTaken=1: the entry SHALL be allocated (overwriting any victim) with valid=1, tag from exPc, target=exIrregPc, counter=2.
REQ-023 On a miss with exBranchTaken=0, the table SHALL NOT change.
REQ-024 When exIsBranch=0, the table SHALL NOT change.
REQ-025 When lookup and update address the same entry in the same cycle, lookup SHALL return pre-update contents (no write-through bypass); the update is visible from the next cycle.
REQ-026 branchCount SHALL increment by 1 per edge with exIsBranch=1; missCount SHALL increment by 1 per edge with isBranchPredictMiss=1; both wrap 0xFFFFFFFF -> 0.

Reset
REQ-027 While rst=0, all entries SHALL be invalid and counters 0.
REQ-028 While rst=0, the following outputs SHALL be 0: predictedNextPc, isBranchTakenPredicted, isNextPcPredicted, isBranchPredictMiss, recoveryPc, branchCount, missCount.
REQ-029 Reset asserted mid-operation SHALL clear state immediately, independent of clk.
REQ-030 The first edge after rst returns to 1 SHALL perform a normal update.

Verification
REQ-031 Cold miss: after reset, fetchPc=0x100 -> predictedNextPc=0x104, both prediction flags 0.
REQ-032 Allocate: exIsBranch=1, taken, exPc=0x100, exIrregPc=0x200, exPredictedNextPc=0x104 -> isBranchPredictMiss=1, recoveryPc=0x200, missCount=1. Next cycle fetchPc=0x100 -> predictedNextPc=0x200, isBranchTakenPredicted=1.
REQ-033 Hysteresis: from counter=2, one not-taken resolve -> prediction becomes not-taken (counter 1); four taken resolves -> counter saturates at 3; one not-taken -> still predicts taken.
REQ-034 Aliasing: entry allocated for 0x100; fetchPc=0x140 with ENTRIES=16 -> tag mismatch, isNextPcPredicted=0. A taken resolve at 0x140 replaces the entry; 0x100 then misses.
REQ-035 Same-cycle hazard: update and lookup of 0x100 in one cycle -> old prediction output that cycle, new prediction the next cycle.
REQ-036 Async reset: pulse rst low between edges -> outputs and counters read 0 before the next clk edge.
